start_done_seq: RTL and testbench
=================================

# start_done_seq

Sequence generator that produces the `start`/`a`/`b`/`done` stimulus pattern consumed by the start-to-done assertion checkers.
- A rising edge on `start` launches one fixed-shape run: `a` held for `A_LEN` cycles, `b` held for `B_LEN` cycles after an offset, then a one-cycle `done` pulse.
- Sits directly upstream of the SVA checker stage and drives its inputs from real RTL instead of hand-timed `#` delays.

## Interface
Parameters:
- `A_LEN`, 2, cycles `a` is high; must be ≥ 1
- `B_OFF`, 1, cycles from first `a` cycle to first `b` cycle; must be ≥ 0
- `B_LEN`, 2, cycles `b` is high; must be ≥ 1
- `DONE_GAP`, 1, cycles from the last cycle covered by `a`/`b` to `done`; must be ≥ 1

Ports:
- `clk` in 1: single clock; all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: trigger; a rising edge launches a run
- `a` out 1: registered
- `b` out 1: registered
- `done` out 1: registered one-cycle pulse
- `busy` out 1: registered; high while a run is in progress
- `start_drop` out 1: registered one-cycle pulse; a rising edge of `start` was ignored
- `run_cnt` out 8: completed runs, saturating at 255

## Operation
- Rise detect: `rise = start & ~start_q`; `start_q` is a register of `start`.
- `start_q` resets to 0, so `start` held high through reset release counts as a rise at the first post-reset edge.
- FSM states: `IDLE`, `RUN`, `DONE`.
- `IDLE` → `RUN` on `rise`. `cnt` loads 1.
- `RUN`: `cnt` increments each cycle.
  - `RUN` → `DONE` when `cnt == T-1`, where `T = max(A_LEN, B_OFF+B_LEN) + DONE_GAP`.
- `DONE` → `IDLE` unconditionally after one cycle. `run_cnt` increments there unless it is already 255.
- Output decode, registered from the next-state/next-count values:
  - `a = 1` for `cnt` in 1..`A_LEN`
  - `b = 1` for `cnt` in `1+B_OFF`..`B_OFF+B_LEN`
  - `done = 1` in `DONE`
  - `busy = 1` in `RUN` or `DONE`
- `rise` while in `RUN` or `DONE` is not queued: the run is unaffected and `start_drop` pulses on the next cycle.
- `cnt` width is `$clog2(T+1)`.
- Reset, including mid-run: on the next edge the state returns to `IDLE` and every output is 0 (`run_cnt` = 0, `start_q` = 0). A partial run does not count toward `run_cnt`.

## Timing
- Cycle 0 is the posedge at which `rise` is sampled.
- `a` is sampled high at cycles 1..`A_LEN`.
- `b` is sampled high at cycles `1+B_OFF`..`B_OFF+B_LEN`.
- `done` is sampled high at cycle `T` only.
- `busy` is sampled high at cycles 1..`T`. `busy` is low at cycle `T+1`.
- A new `rise` sampled at cycle `T` is dropped. A new `rise` sampled at cycle `T+1` starts a run, giving back-to-back runs with period `T+1`.
- Defaults give `T = 4`:
  - `a` at cycles 1-2
  - `b` at cycles 2-3
  - `done` at cycle 4
- `start` held high for multiple cycles triggers only once.

## Configuration
- `START_DONE_SEQ_ASSERT_EN` defined: the block embeds concurrent assertions on `clk`, all disabled by `rst`:
  - `rise && !busy |=> a[*A_LEN]`
  - `rise && !busy |-> ##(1+B_OFF) b[*B_LEN]`
  - `rise && !busy |-> ##T done ##1 !done`
  - `done |-> busy`
  - Each assertion prints `$info` on success and `$error` on failure.
- Macro undefined: no assertion code is compiled. RTL behaviour is identical in both cases.

## Test plan
- Defaults, `start` 0→1 at cycle 0 for one cycle → `a` high at cycles 1-2, `b` high at cycles 2-3, `done` at cycle 4, `busy` high at cycles 1-4, `run_cnt` = 1.
- Defaults, second `start` rise at cycle 2 → run shape unchanged, `start_drop` pulses at cycle 3, `run_cnt` = 1 after `done`.
- Defaults, `start` held high for 10 cycles → exactly one run, no `start_drop`.
- Defaults, `rst` asserted at cycle 2 of a run → all outputs 0 at cycle 3, `run_cnt` = 0; a fresh rise afterwards produces a full run.
- `A_LEN=3`, `B_OFF=0`, `B_LEN=5`, `DONE_GAP=2` → `a` at cycles 1-3, `b` at cycles 1-5, `done` at cycle 7; back-to-back rise at cycle 8 starts the next run.
- 260 back-to-back runs → `run_cnt` saturates at 255 with no wrap.

Source files
------------

// File: rtl/start_done_seq.sv
// rtl/start_done_seq.sv - start-to-done stimulus sequencer: one a/b/done run per rising edge of start
// Optional START_DONE_SEQ_ASSERT_EN embeds concurrent checks of the run shape.
module start_done_seq #(
  parameter int A_LEN    = 2,
  parameter int B_OFF    = 1,
  parameter int B_LEN    = 2,
  parameter int DONE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       done,
  output logic       busy,
  output logic       start_drop,
  output logic [7:0] run_cnt
);

  localparam int AB_END = (A_LEN > B_OFF + B_LEN) ? A_LEN : (B_OFF + B_LEN);
  localparam int T      = AB_END + DONE_GAP;
  localparam int CW     = $clog2(T + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(T - 1);
  localparam logic [CW-1:0] A_HI     = CW'(A_LEN);
  localparam logic [CW-1:0] B_LO     = CW'(1 + B_OFF);
  localparam logic [CW-1:0] B_HI     = CW'(B_OFF + B_LEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          start_q;
  logic          rise;
  logic          in_run;
  logic          a_nxt;
  logic          b_nxt;
  logic          drop_nxt;

  assign rise = start & ~start_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = RUN;
          cnt_nxt   = CNT_ONE;
        end
      end
      RUN: begin
        cnt_nxt = cnt + CNT_ONE;
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they line up with cnt one cycle after the rise.
  assign in_run   = (state_nxt == RUN);
  assign a_nxt    = in_run && (cnt_nxt <= A_HI);
  assign b_nxt    = in_run && (cnt_nxt >= B_LO) && (cnt_nxt <= B_HI);
  assign drop_nxt = rise && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      start_q    <= 1'b0;
      a          <= 1'b0;
      b          <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      start_drop <= 1'b0;
      run_cnt    <= 8'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      start_q    <= start;
      a          <= a_nxt;
      b          <= b_nxt;
      done       <= (state_nxt == DONE);
      busy       <= (state_nxt != IDLE);
      start_drop <= drop_nxt;
      if ((state == DONE) && (run_cnt != 8'hFF)) begin
        run_cnt <= run_cnt + 8'd1;
      end
    end
  end

`ifdef START_DONE_SEQ_ASSERT_EN
  ap_a_len: assert property (@(posedge clk) disable iff (rst)
    rise && !busy |=> a [* A_LEN])
    $info("ap_a_len ok"); else $error("ap_a_len violated");

  ap_b_len: assert property (@(posedge clk) disable iff (rst)
    rise && !busy |-> ##(1 + B_OFF) b [* B_LEN])
    $info("ap_b_len ok"); else $error("ap_b_len violated");

  ap_done: assert property (@(posedge clk) disable iff (rst)
    rise && !busy |-> ##T done ##1 !done)
    $info("ap_done ok"); else $error("ap_done violated");

  ap_done_busy: assert property (@(posedge clk) disable iff (rst)
    done |-> busy)
    $info("ap_done_busy ok"); else $error("ap_done_busy violated");
`else
`endif

endmodule

// File: tb/tb_start_done_seq.sv
// tb/tb_start_done_seq.sv - self-checking bench for start_done_seq, two parameter sets driven in parallel
module tb_start_done_seq;

  localparam int NONE = -1000000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       a0, b0, d0, bz0, sd0;
  logic       a1, b1, d1, bz1, sd1;
  logic [7:0] rc0, rc1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int pa[2]  = '{2, 3};
  int pbo[2] = '{1, 0};
  int pbl[2] = '{2, 5};
  int pg[2]  = '{1, 2};
  int pt[2];
  int r[2];
  int runs[2];
  bit prv[2];

  always #5 clk = ~clk;

  start_done_seq u_dut0 (
    .clk(clk), .rst(rst), .start(start), .a(a0), .b(b0), .done(d0),
    .busy(bz0), .start_drop(sd0), .run_cnt(rc0)
  );

  start_done_seq #(.A_LEN(3), .B_OFF(0), .B_LEN(5), .DONE_GAP(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a1), .b(b1), .done(d1),
    .busy(bz1), .start_drop(sd1), .run_cnt(rc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Timeline model: each accepted rise at edge r owns sample cycles r+1..r+T.
  task automatic step(input bit r_in, input bit s_in);
    bit rise;
    bit drop;
    int d;
    rst   = r_in;
    start = s_in;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      drop = 1'b0;
      if (r_in) begin
        r[i]    = NONE;
        runs[i] = 0;
        prv[i]  = 1'b0;
      end else begin
        rise   = s_in && !prv[i];
        prv[i] = s_in;
        if (r[i] != NONE && cyc - r[i] == pt[i] && runs[i] < 255) runs[i]++;
        if (rise) begin
          if (r[i] != NONE && cyc - r[i] >= 1 && cyc - r[i] <= pt[i]) drop = 1'b1;
          else r[i] = cyc;
        end
      end
      d = (r[i] == NONE) ? NONE : cyc + 1 - r[i];
      check($sformatf("i%0d_a", i), 32'(i == 0 ? a0 : a1), 32'(d >= 1 && d <= pa[i]));
      check($sformatf("i%0d_b", i), 32'(i == 0 ? b0 : b1),
            32'(d >= 1 + pbo[i] && d <= pbo[i] + pbl[i]));
      check($sformatf("i%0d_done", i), 32'(i == 0 ? d0 : d1), 32'(d == pt[i]));
      check($sformatf("i%0d_busy", i), 32'(i == 0 ? bz0 : bz1), 32'(d >= 1 && d <= pt[i]));
      check($sformatf("i%0d_drop", i), 32'(i == 0 ? sd0 : sd1), 32'(drop));
      check($sformatf("i%0d_run_cnt", i), 32'(i == 0 ? rc0 : rc1), 32'(runs[i]));
    end
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pt[i]   = ((pa[i] > pbo[i] + pbl[i]) ? pa[i] : pbo[i] + pbl[i]) + pg[i];
      r[i]    = NONE;
      runs[i] = 0;
      prv[i]  = 1'b0;
    end
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) step(1'b1, 1'b0);

    // single one-cycle pulse
    step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);

    // second rise two cycles into a run is dropped
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);

    // start held high triggers once
    repeat (10) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);

    // reset mid-run, then a fresh run
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);

    // back-to-back at period T+1 for each parameter set
    repeat (6) begin
      step(1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0);
    end
    repeat (4) begin
      step(1'b0, 1'b1);
      repeat (7) step(1'b0, 1'b0);
    end
    repeat (10) step(1'b0, 1'b0);

    // enough runs on both instances to saturate run_cnt
    repeat (1200) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    repeat (10) step(1'b0, 1'b0);
    check("sat0", 32'(rc0), 32'd255);
    check("sat1", 32'(rc1), 32'd255);

    // random start with occasional reset
    repeat (800) step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
